// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and the main decoder:
// opcodes, FSM state codes, memory access codes, ALU_op and result_select codes.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // FSM state encoding, kept as plain constants so legacy tools can share it
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_ADDRESS   = 4'd2;
    localparam logic [3:0] S_MEMORY    = 4'd3;
    localparam logic [3:0] S_EXECUTE   = 4'd4;
    localparam logic [3:0] S_WRITEBACK = 4'd5;
    localparam logic [3:0] S_BRANCH    = 4'd6;
    localparam logic [3:0] S_JUMP      = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    // memory_control: {unsigned, half, byte, write}
    localparam int         MEM_CTRL_W = 4;
    localparam logic [3:0] MC_LW  = 4'b0000;
    localparam logic [3:0] MC_SW  = 4'b0001;
    localparam logic [3:0] MC_LB  = 4'b0010;
    localparam logic [3:0] MC_SB  = 4'b0011;
    localparam logic [3:0] MC_LH  = 4'b0100;
    localparam logic [3:0] MC_SH  = 4'b0101;
    localparam logic [3:0] MC_LBU = 4'b1010;
    localparam logic [3:0] MC_LHU = 4'b1100;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    localparam logic [2:0] RS_ALU    = 3'b000;
    localparam logic [2:0] RS_MEMORY = 3'b001;
    localparam logic [2:0] RS_PC4    = 3'b010;
    localparam logic [2:0] RS_IMM    = 3'b011;
    localparam logic [2:0] RS_PC_IMM = 3'b100;

    // Width/sign variants that exist in RV32I for loads and stores
    function automatic logic access_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 <= 3'b010);
        return (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    endfunction

    function automatic logic [3:0] mem_control(input logic is_store, input logic [2:0] funct3);
        logic [3:0] code;
        code = MC_LW;
        unique case ({is_store, funct3})
            4'b0_000: code = MC_LB;
            4'b0_001: code = MC_LH;
            4'b0_010: code = MC_LW;
            4'b0_100: code = MC_LBU;
            4'b0_101: code = MC_LHU;
            4'b1_000: code = MC_SB;
            4'b1_001: code = MC_SH;
            4'b1_010: code = MC_SW;
            default:  code = MC_LW;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request/ready handshake between the controller and the shared memory.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic                  memory_request;
    logic                  memory_write;
    logic [MEM_CTRL_W-1:0] memory_control;
    logic                  address_select;
    logic                  memory_ready;

    modport master (
        output memory_request, memory_write, memory_control, address_select,
        input  memory_ready
    );

    modport slave (
        input  memory_request, memory_write, memory_control, address_select,
        output memory_ready
    );
endinterface

// File: rtl/multicycle_controller_memory_wait_timer.sv
// Counts consecutive stalled memory cycles and flags when the limit is hit.
// A ready in the limit cycle suppresses expired, so completion wins.
module memory_wait_timer #(
    parameter int MEMORY_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting,
    input  logic ready,
    output logic expired
);
    localparam int CW        = (MEMORY_TIMEOUT > 2) ? $clog2(MEMORY_TIMEOUT) : 1;
    localparam int LIMIT_INT = (MEMORY_TIMEOUT > 0) ? MEMORY_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIMIT_INT);

    logic [CW-1:0] r_count;
    logic          w_stall;

    // The FSM never moves directly between two waiting states without a
    // ready, so clearing on "not stalled" also covers every state change.
    assign w_stall = waiting && !ready;
    assign expired = (MEMORY_TIMEOUT > 0) && w_stall && (r_count == LIMIT);

    // Stall counter: cleared by reset, ready or leaving a waiting state
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset || !w_stall)
            r_count <= '0;
        else if (r_count != LIMIT)
            r_count <= r_count + CW'(1);
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: fetch/decode/execute/memory/writeback,
// memory handshake with timeout, sticky fault and retired-instruction counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEMORY_TIMEOUT = 16,
    parameter int RETIRED_WIDTH  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    multicycle_controller_if.master  mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_write,
    output logic                     ALU_select,
    output logic [1:0]               ALU_op,
    output logic [2:0]               result_select,
    output logic                     branch,
    output logic                     jump,
    output logic                     fault,
    output logic [RETIRED_WIDTH-1:0] retired
);
    logic [3:0]               r_state;
    logic [3:0]               w_next_state;
    logic                     w_retire;
    logic                     w_waiting;
    logic                     w_expired;
    logic                     w_is_store;
    logic [RETIRED_WIDTH-1:0] r_retired;
    logic                     w_mem_request;
    logic                     w_mem_write;
    logic [MEM_CTRL_W-1:0]    w_mem_control;
    logic                     w_address_select;

    assign w_is_store = (opcode == OP_STORE);
    assign w_waiting  = (r_state == S_FETCH) || (r_state == S_MEMORY);

    memory_wait_timer #(.MEMORY_TIMEOUT(MEMORY_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .waiting (w_waiting),
        .ready   (mem.memory_ready),
        .expired (w_expired)
    );

    // Next-state and retire decision
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_next_state = r_state;
        w_retire     = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (mem.memory_ready)  w_next_state = S_DECODE;
                else if (w_expired)    w_next_state = S_FAULT;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE:
                        w_next_state = access_legal(w_is_store, funct3) ? S_ADDRESS : S_FAULT;
                    OP_REG, OP_IMM:     w_next_state = S_EXECUTE;
                    OP_BRANCH:          w_next_state = S_BRANCH;
                    OP_JAL, OP_JALR:    w_next_state = S_JUMP;
                    OP_LUI, OP_AUIPC:   w_next_state = S_WRITEBACK;
                    default:            w_next_state = S_FAULT;
                endcase
            end
            S_ADDRESS: w_next_state = S_MEMORY;
            S_MEMORY: begin
                if (mem.memory_ready) begin
                    w_next_state = w_is_store ? S_FETCH : S_WRITEBACK;
                    w_retire     = w_is_store;
                end else if (w_expired) begin
                    w_next_state = S_FAULT;
                end
            end
            S_EXECUTE: w_next_state = S_WRITEBACK;
            S_WRITEBACK, S_BRANCH, S_JUMP: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            default: w_next_state = S_FAULT;
        endcase
    end

    // State register and retired counter; reset abandons any pending request
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_retired <= r_retired + RETIRED_WIDTH'(1);
        end
    end

    // Control outputs from state/opcode/funct3, all forced low during reset
    always_comb begin
        w_mem_request    = 1'b0;
        w_mem_write      = 1'b0;
        w_mem_control    = MC_LW;
        w_address_select = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        reg_write        = 1'b0;
        ALU_select       = 1'b0;
        ALU_op           = ALU_OP_ADD;
        result_select    = RS_ALU;
        branch           = 1'b0;
        jump             = 1'b0;
        fault            = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_FETCH: begin
                    w_mem_request = 1'b1;
                    ir_write      = mem.memory_ready;
                    pc_write      = mem.memory_ready;
                end
                S_ADDRESS: ALU_select = 1'b1;
                S_MEMORY: begin
                    w_mem_request    = 1'b1;
                    w_address_select = 1'b1;
                    w_mem_write      = w_is_store;
                    w_mem_control    = mem_control(w_is_store, funct3);
                end
                S_EXECUTE: begin
                    ALU_select = (opcode == OP_IMM);
                    ALU_op     = ALU_OP_FUNCT;
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    unique case (opcode)
                        OP_LOAD:  result_select = RS_MEMORY;
                        OP_LUI:   result_select = RS_IMM;
                        OP_AUIPC: result_select = RS_PC_IMM;
                        default:  result_select = RS_ALU;
                    endcase
                end
                S_BRANCH: begin
                    ALU_op = ALU_OP_BRANCH;
                    branch = 1'b1;
                end
                S_JUMP: begin
                    jump          = 1'b1;
                    pc_write      = 1'b1;
                    reg_write     = 1'b1;
                    result_select = RS_PC4;
                    ALU_select    = (opcode == OP_JALR);
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem.memory_request = w_mem_request;
    assign mem.memory_write   = w_mem_write;
    assign mem.memory_control = w_mem_control;
    assign mem.address_select = w_address_select;
    assign retired            = r_retired;
endmodule
